act_lut_writer: RTL

Runtime-loadable activation lookup table for the CNN datapath. It is the writer side of the activation LUT: it accepts a stream of table entries from the host/config path and stores them in a 2^dataWidth-entry register array. It then serves pipelined lookups with valid/ready handshakes, so tanh, sigmoid or any other int8→int8 activation can be swapped without resynthesis. It sits between the post-accumulation requantizer and the pooling/output buffer.

---
 rtl/act_lut_writer_if.sv | 28 ++
 rtl/act_lut_writer.sv | 83 ++++++++
 2 files changed

// File: rtl/act_lut_writer_if.sv
// Handshake bundle for the activation LUT: table-load stream, lookup operand
// stream and lookup result stream, plus load status.
interface act_lut_writer_if #(
  parameter int dataWidth = 8
);
  logic                        load_start;
  logic                        wr_valid;
  logic signed [dataWidth-1:0] wr_data;
  logic                        wr_ready;
  logic                        load_done;
  logic                        busy;
  logic                        in_valid;
  logic signed [dataWidth-1:0] in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic signed [dataWidth-1:0] out_data;
  logic                        out_ready;

  modport master (
    output load_start, wr_valid, wr_data, in_valid, in_data, out_ready,
    input  wr_ready, load_done, busy, in_ready, out_valid, out_data
  );

  modport slave (
    input  load_start, wr_valid, wr_data, in_valid, in_data, out_ready,
    output wr_ready, load_done, busy, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/act_lut_writer.sv
// Runtime-loadable 2^dataWidth-entry activation LUT; one-cycle lookup latency.
// Lookup stalls (in_ready=0) while a held result is not taken; load_start flushes it.
module act_lut_writer #(
  parameter int dataWidth = 8
) (
  input logic             clk,
  input logic             rst_n,
  act_lut_writer_if.slave bus
);

  localparam int depth = 2 ** dataWidth;

  typedef enum logic [1:0] {EMPTY, LOAD, ACTIVE} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic        [dataWidth-1:0] cnt;
  logic signed [dataWidth-1:0] lut [depth];
  logic                        out_valid_q;
  logic signed [dataWidth-1:0] out_data_q;
  logic                        wr_acc;
  logic                        in_acc;
  logic                        last_beat;
  logic        [dataWidth-1:0] addr;

  assign wr_acc    = bus.wr_valid && bus.wr_ready;
  assign in_acc    = bus.in_valid && bus.in_ready;
  assign last_beat = (cnt == {dataWidth{1'b1}});
  // Adding half the range to a two's-complement operand just flips its MSB.
  assign addr      = {~bus.in_data[dataWidth-1], bus.in_data[dataWidth-2:0]};

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    state_nxt     = state;
    bus.wr_ready  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.load_done = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      EMPTY: begin
        if (bus.load_start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.busy     = 1'b1;
        bus.wr_ready = !bus.load_start;
        if (!bus.load_start && bus.wr_valid && last_beat) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        bus.load_done = 1'b1;
        bus.in_ready  = !bus.load_start && (!out_valid_q || bus.out_ready);
        if (bus.load_start) state_nxt = LOAD;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (bus.load_start) cnt <= '0;
      else if (wr_acc)    cnt <= cnt + dataWidth'(1);

      if (bus.load_start)     out_valid_q <= 1'b0;
      else if (in_acc)        out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;

      if (in_acc) out_data_q <= lut[addr];
    end
  end

  // Table storage carries no reset; it is only meaningful once load_done is high.
  always_ff @(posedge clk) begin
    if (wr_acc) lut[cnt] <= bus.wr_data;
  end

endmodule
